// File: rtl/alu_nibble_seq_if.sv
// Control-side bus between the microcode control unit (master) and the
// nibble-serial ALU sequencer (slave).
interface alu_nibble_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic [3:0]   op_s;
    logic         op_m;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         eq;

    modport master (
        output start, op_s, op_m, cin, a, b,
        input  busy, done, result, cout, zero, eq
    );

    modport slave (
        input  start, op_s, op_m, cin, a, b,
        output busy, done, result, cout, zero, eq
    );
endinterface

// File: rtl/alu_nibble_seq.sv
// Runs one external 74181 slice nibble-serially to perform a W-bit operation,
// chaining the slice's active-low carry from nibble to nibble.
//
// state   | meaning
// IDLE    | waiting for start; slice outputs hold their last values
// RUN     | presenting nibble n, settling, then capturing F / carry / A=B
// DONE    | one-cycle completion pulse; start is ignored here
module alu_nibble_seq #(
    parameter int NIBBLES = 4,
    parameter int SETTLE  = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    alu_nibble_seq_if.slave  bus,
    output logic [3:0]       alu_s_o,
    output logic             alu_m_o,
    output logic             alu_cnb_o,
    output logic [3:0]       alu_a_o,
    output logic [3:0]       alu_b_o,
    input  logic [3:0]       alu_f_i,
    input  logic             alu_cn4b_i,
    input  logic             alu_aeb_i
);
    localparam int W     = 4 * NIBBLES;
    localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             cnb_q, cnb_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             eqacc_q, eqacc_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             eq_q, eq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            cnb_q    <= 1'b1;
            nib_q    <= '0;
            settle_q <= '0;
            eqacc_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            cnb_q    <= cnb_d;
            nib_q    <= nib_d;
            settle_q <= settle_d;
            eqacc_q  <= eqacc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        cnb_d    = cnb_q;
        nib_d    = nib_q;
        settle_d = settle_q;
        eqacc_d  = eqacc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        eq_d     = eq_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    s_d      = bus.op_s;
                    m_d      = bus.op_m;
                    cnb_d    = ~bus.cin;
                    nib_d    = '0;
                    settle_d = SETTLE_LD;
                    eqacc_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else begin
                    // Slice outputs are stable: capture this nibble and chain the carry.
                    result_d[{nib_q, 2'b00} +: 4] = alu_f_i;
                    cnb_d   = alu_cn4b_i;
                    eqacc_d = eqacc_q & alu_aeb_i;
                    if (nib_q == LAST_NIB) begin
                        cout_d  = ~alu_cn4b_i;
                        zero_d  = (result_d == '0);
                        eq_d    = eqacc_d;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        nib_d    = nib_q + 1'b1;
                        settle_d = SETTLE_LD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign alu_s_o   = s_q;
    assign alu_m_o   = m_q;
    assign alu_cnb_o = cnb_q;
    assign alu_a_o   = a_q[{nib_q, 2'b00} +: 4];
    assign alu_b_o   = b_q[{nib_q, 2'b00} +: 4];

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;
    assign bus.eq     = eq_q;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench: two sequencers (SETTLE=0 and SETTLE=2), each wired to a
// behavioural 74181 slice model, checked against hand-computed results.
module tb_alu_nibble_seq;
    logic clk;
    logic reset;

    logic        sel;
    logic        start_r;
    logic [3:0]  op_s_r;
    logic        op_m_r;
    logic        cin_r;
    logic [15:0] a_r;
    logic [15:0] b_r;

    int n_chk;
    int n_pass;
    int n_fail;

    logic [3:0] a_log [64];
    logic       cnb_log [64];

    alu_nibble_seq_if #(.W(16)) bus0 ();
    alu_nibble_seq_if #(.W(16)) bus1 ();

    logic [3:0] s0, a0, b0, f0, s1, a1, b1, f1;
    logic       m0, cnb0, cn4b0, aeb0, m1, cnb1, cn4b1, aeb1;

    // Behavioural 74181 subset (active-high data): ADD, SUB, XOR.
    // A=B is modelled as a direct nibble compare.
    function automatic logic [5:0] f181(input logic [3:0] s, input logic m,
                                        input logic cnb, input logic [3:0] x,
                                        input logic [3:0] y);
        logic [4:0] sum;
        logic [3:0] f;
        logic       c4b;
        sum = '0;
        f   = '0;
        c4b = 1'b1;
        if (m) begin
            f   = (s == 4'b0110) ? (x ^ y) : ~x;
            c4b = cnb;
        end else begin
            case (s)
                4'b1001: sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cnb};
                4'b0110: sum = {1'b0, x} + {1'b0, ~y} + {4'b0, ~cnb};
                default: sum = {1'b0, x} + {4'b0, ~cnb};
            endcase
            f   = sum[3:0];
            c4b = ~sum[4];
        end
        return {(x == y), c4b, f};
    endfunction

    assign {aeb0, cn4b0, f0} = f181(s0, m0, cnb0, a0, b0);
    assign {aeb1, cn4b1, f1} = f181(s1, m1, cnb1, a1, b1);

    assign bus0.start = start_r & ~sel;
    assign bus1.start = start_r & sel;
    assign bus0.op_s = op_s_r;
    assign bus1.op_s = op_s_r;
    assign bus0.op_m = op_m_r;
    assign bus1.op_m = op_m_r;
    assign bus0.cin  = cin_r;
    assign bus1.cin  = cin_r;
    assign bus0.a    = a_r;
    assign bus1.a    = a_r;
    assign bus0.b    = b_r;
    assign bus1.b    = b_r;

    alu_nibble_seq #(.NIBBLES(4), .SETTLE(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .bus(bus0),
        .alu_s_o(s0), .alu_m_o(m0), .alu_cnb_o(cnb0), .alu_a_o(a0), .alu_b_o(b0),
        .alu_f_i(f0), .alu_cn4b_i(cn4b0), .alu_aeb_i(aeb0)
    );

    alu_nibble_seq #(.NIBBLES(4), .SETTLE(2)) dut1 (
        .clk_i(clk), .reset_i(reset), .bus(bus1),
        .alu_s_o(s1), .alu_m_o(m1), .alu_cnb_o(cnb1), .alu_a_o(a1), .alu_b_o(b1),
        .alu_f_i(f1), .alu_cn4b_i(cn4b1), .alu_aeb_i(aeb1)
    );

    logic        o_busy, o_done, o_cout, o_zero, o_eq, o_cnb;
    logic [15:0] o_result;
    logic [3:0]  o_alu_a;
    assign o_busy   = sel ? bus1.busy   : bus0.busy;
    assign o_done   = sel ? bus1.done   : bus0.done;
    assign o_result = sel ? bus1.result : bus0.result;
    assign o_cout   = sel ? bus1.cout   : bus0.cout;
    assign o_zero   = sel ? bus1.zero   : bus0.zero;
    assign o_eq     = sel ? bus1.eq     : bus0.eq;
    assign o_cnb    = sel ? cnb1        : cnb0;
    assign o_alu_a  = sel ? a1          : a0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an operation, then samples 1 ns after every edge until done.
    // lat = edges after the start edge at which done is first seen.
    task automatic run_op(input logic [3:0] s, input logic m, input logic c,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic inject, output int lat, output int busy_cnt);
        op_s_r  = s;
        op_m_r  = m;
        cin_r   = c;
        a_r     = x;
        b_r     = y;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        lat      = 0;
        busy_cnt = int'(o_busy);
        a_log[0]   = o_alu_a;
        cnb_log[0] = o_cnb;
        while (!o_done && lat < 40) begin
            if (inject && lat == 1) begin
                a_r     = 16'h1111;
                b_r     = 16'h2222;
                op_s_r  = 4'b1001;
                op_m_r  = 1'b0;
                start_r = 1'b1;
            end
            tick();
            start_r = 1'b0;
            lat++;
            busy_cnt += int'(o_busy);
            a_log[lat]   = o_alu_a;
            cnb_log[lat] = o_cnb;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dones;
        n_chk   = 0;
        n_pass  = 0;
        n_fail  = 0;
        sel     = 1'b0;
        start_r = 1'b0;
        op_s_r  = '0;
        op_m_r  = 1'b0;
        cin_r   = 1'b0;
        a_r     = '0;
        b_r     = '0;
        reset   = 1'b1;
        #12;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_flags", {29'd0, o_cout, o_zero, o_eq}, 32'd0);
        check("rst_cnb", 32'(cnb0), 32'd1);
        check("rst_alu_a", 32'(a0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        run_op(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0, lat, bc);
        check("add_lat", 32'(lat), 32'd4);
        check("add_busy_cycles", 32'(bc), 32'd4);
        check("add_result", 32'(o_result), 32'h5555);
        check("add_cout", 32'(o_cout), 32'd0);
        check("add_zero", 32'(o_zero), 32'd0);
        tick();
        check("add_done_pulse", 32'(o_done), 32'd0);

        run_op(4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, lat, bc);
        check("wrap_lat", 32'(lat), 32'd4);
        check("wrap_result", 32'(o_result), 32'h0000);
        check("wrap_cout", 32'(o_cout), 32'd1);
        check("wrap_zero", 32'(o_zero), 32'd1);
        check("wrap_cnb_n0", 32'(cnb_log[0]), 32'd1);
        check("wrap_cnb_n1", 32'(cnb_log[1]), 32'd0);
        check("wrap_cnb_n2", 32'(cnb_log[2]), 32'd0);
        check("wrap_cnb_n3", 32'(cnb_log[3]), 32'd0);
        tick();

        run_op(4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0, lat, bc);
        check("sub_eq_result", 32'(o_result), 32'h0000);
        check("sub_eq_cout", 32'(o_cout), 32'd1);
        check("sub_eq_eq", 32'(o_eq), 32'd1);
        check("sub_eq_zero", 32'(o_zero), 32'd1);
        tick();

        run_op(4'b0110, 1'b0, 1'b1, 16'h0003, 16'h0005, 1'b0, lat, bc);
        check("sub_ne_result", 32'(o_result), 32'hFFFE);
        check("sub_ne_cout", 32'(o_cout), 32'd0);
        check("sub_ne_eq", 32'(o_eq), 32'd0);
        check("sub_ne_zero", 32'(o_zero), 32'd0);
        tick();

        run_op(4'b0110, 1'b1, 1'b0, 16'hF0F0, 16'hFF00, 1'b1, lat, bc);
        check("xor_lat", 32'(lat), 32'd4);
        check("xor_result", 32'(o_result), 32'h0FF0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            dones += int'(o_done);
        end
        check("xor_no_second_done", 32'(dones), 32'd0);
        check("xor_result_held", 32'(o_result), 32'h0FF0);
        check("xor_idle_busy", 32'(o_busy), 32'd0);

        op_s_r  = 4'b1001;
        op_m_r  = 1'b0;
        cin_r   = 1'b0;
        a_r     = 16'h1234;
        b_r     = 16'h4321;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", 32'(o_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        check("midrst_result", 32'(o_result), 32'd0);
        check("midrst_cnb", 32'(cnb0), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_op(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0, lat, bc);
        check("postrst_lat", 32'(lat), 32'd4);
        check("postrst_result", 32'(o_result), 32'h5555);
        tick();

        sel = 1'b1;
        run_op(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0, lat, bc);
        check("settle_lat", 32'(lat), 32'd12);
        check("settle_busy_cycles", 32'(bc), 32'd12);
        check("settle_result", 32'(o_result), 32'h5555);
        check("settle_cout", 32'(o_cout), 32'd0);
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("settle_alu_a_n%0d_c%0d", n, k),
                      32'(a_log[3 * n + k]), 32'((16'h1234 >> (4 * n)) & 16'hF));
            end
        end
        tick();
        check("settle_done_pulse", 32'(o_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
